// File: rtl/pipe_pkg.sv
// Shared definitions for the valid/ready pipeline stage registers.
// State encoding doubles as the occupancy count.
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 3;
  localparam int DEF_TAG_W  = 12;

  typedef logic [1:0] state_t;

  localparam state_t ST_EMPTY = 2'd0;
  localparam state_t ST_ONE   = 2'd1;
  localparam state_t ST_TWO   = 2'd2;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry: valid flag plus ctrl/tag/data payload.
// Clear drops valid and zeroes ctrl; tag and data keep their value.
module pipe_slot #(
  parameter int CTRL_W = 3,
  parameter int TAG_W  = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] wr_ctrl,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [TAG_W-1:0]  tag,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      tag   <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= wr_ctrl;
      tag   <= wr_tag;
      data  <= wr_data;
    end
  end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage register with a 2-entry skid buffer and flush.
// in_ready is a flop that tracks "next state is not full".
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  state_t state, state_nxt;

  logic head_valid, skid_valid;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl, head_wctrl;
  logic [TAG_W-1:0]  head_tag, skid_tag, head_wtag;
  logic [DATA_W-1:0] skid_data, head_wdata;

  logic accept, consume;
  logic head_load, head_clear;
  logic skid_load, skid_clear;

  assign accept  = in_valid & in_ready;
  assign consume = head_valid & out_ready;

  always_comb begin
    state_nxt  = state;
    head_load  = 1'b0;
    head_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      state_nxt  = ST_EMPTY;
      head_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: if (accept) begin
          state_nxt = ST_ONE;
          head_load = 1'b1;
        end
        ST_ONE: begin
          if (accept && consume) begin
            head_load = 1'b1;
          end else if (accept) begin
            state_nxt = ST_TWO;
            skid_load = 1'b1;
          end else if (consume) begin
            state_nxt  = ST_EMPTY;
            head_clear = 1'b1;
          end
        end
        ST_TWO: if (consume && skid_valid) begin
          state_nxt  = ST_ONE;
          head_load  = 1'b1;
          skid_clear = 1'b1;
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Refill from the skid slot when draining a full stage.
  always_comb begin
    head_wctrl = in_ctrl;
    head_wtag  = in_tag;
    head_wdata = in_data;
    if (state == ST_TWO) begin
      head_wctrl = skid_ctrl;
      head_wtag  = skid_tag;
      head_wdata = skid_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != ST_TWO);
    end
  end

  pipe_slot #(
    .CTRL_W(CTRL_W), .TAG_W(TAG_W), .DATA_W(DATA_W)
  ) u_head (
    .clk(clk), .rst(rst),
    .load(head_load), .clear(head_clear),
    .wr_ctrl(head_wctrl), .wr_tag(head_wtag),
    .wr_data(head_wdata),
    .valid(head_valid), .ctrl(head_ctrl),
    .tag(head_tag), .data(out_data)
  );

  pipe_slot #(
    .CTRL_W(CTRL_W), .TAG_W(TAG_W), .DATA_W(DATA_W)
  ) u_skid (
    .clk(clk), .rst(rst),
    .load(skid_load), .clear(skid_clear),
    .wr_ctrl(in_ctrl), .wr_tag(in_tag),
    .wr_data(in_data),
    .valid(skid_valid), .ctrl(skid_ctrl),
    .tag(skid_tag), .data(skid_data)
  );

  assign out_valid = head_valid;
  assign out_ctrl  = head_ctrl & {CTRL_W{head_valid}};
  assign out_tag   = head_tag;
  assign occupancy = state;

endmodule
